da_slice_accumulator: RTL and testbench

Shift-accumulate back end of the distributed-arithmetic FIR. The bit-slice serializer delivers one MSB-first slice per cycle as eight 8-bit LUT addresses. Eight coefficient LUTs turn those addresses into signed partial sums p0..p7, and this block consumes them. Per output sample it sums the eight partials, combines 16 slices by MSB-first Horner accumulation with two's-complement sign weighting, and emits one full-precision filter output with a valid strobe.

---
 rtl/da_slice_accumulator.sv | 122 ++++++++++++
 tb/tb_da_slice_accumulator.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/da_slice_accumulator.sv
// Shift-accumulate back end of the distributed-arithmetic FIR.
// Sums eight signed LUT partials per bit slice and combines NSLICE
// MSB-first slices by Horner accumulation, with the first slice weighted
// negatively as the two's-complement sign bit.
module da_slice_accumulator #(
  parameter int PW     = 24,
  parameter int NSLICE = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          slice_valid,
  input  logic signed [PW-1:0]          p0,
  input  logic signed [PW-1:0]          p1,
  input  logic signed [PW-1:0]          p2,
  input  logic signed [PW-1:0]          p3,
  input  logic signed [PW-1:0]          p4,
  input  logic signed [PW-1:0]          p5,
  input  logic signed [PW-1:0]          p6,
  input  logic signed [PW-1:0]          p7,
  output logic signed [PW+3+NSLICE-1:0] y,
  output logic                          y_valid,
  output logic                          busy,
  output logic                          frame_err
);

  localparam int SW = PW + 3;
  localparam int AW = SW + NSLICE;
  localparam int CW = $clog2(NSLICE);

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t               state;
  logic [CW-1:0]        cnt;

  logic                 s1_valid;
  logic                 s1_first;
  logic                 s1_last;
  logic signed [SW-1:0] s1_sum;

  logic signed [AW-1:0] acc;

  logic signed [SW-1:0] slice_sum;
  logic                 accept_first;
  logic                 accept_next;
  logic                 is_last;
  logic signed [AW-1:0] s_ext;
  logic signed [AW-1:0] acc_next;

  function automatic logic signed [SW-1:0] sx(input logic signed [PW-1:0] v);
    return {{(SW-PW){v[PW-1]}}, v};
  endfunction

  // Adder tree and slice acceptance decode.
  always_comb begin
    slice_sum    = sx(p0) + sx(p1) + sx(p2) + sx(p3)
                 + sx(p4) + sx(p5) + sx(p6) + sx(p7);
    accept_first = slice_valid & start;
    accept_next  = slice_valid & ~start & (state == ACCUM);
    is_last      = accept_next & (cnt == CW'(NSLICE - 1));
  end

  // Frame FSM, slice counter and stage-1 register (sum plus first/last tags).
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      frame_err <= 1'b0;
      s1_valid  <= 1'b0;
      s1_first  <= 1'b0;
      s1_last   <= 1'b0;
      s1_sum    <= '0;
    end else begin
      // A start while already accumulating aborts the partial frame; the
      // new slice simply restarts the accumulator as slice 0.
      frame_err <= (state == ACCUM) & accept_first;
      s1_valid  <= accept_first | accept_next;
      s1_first  <= accept_first;
      s1_last   <= is_last;
      if (accept_first | accept_next) begin
        s1_sum <= slice_sum;
      end
      if (accept_first) begin
        state <= ACCUM;
        cnt   <= CW'(1);
      end else if (accept_next) begin
        if (is_last) begin
          state <= IDLE;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

  // Horner step: sign slice enters negated, later slices shift-and-add.
  always_comb begin
    s_ext    = {{NSLICE{s1_sum[SW-1]}}, s1_sum};
    acc_next = s1_first ? -s_ext : ((acc <<< 1) + s_ext);
  end

  // Stage-2 accumulator and output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc     <= '0;
      y       <= '0;
      y_valid <= 1'b0;
    end else begin
      y_valid <= s1_valid & s1_last;
      if (s1_valid) begin
        acc <= acc_next;
        if (s1_last) begin
          y <= acc_next;
        end
      end
    end
  end

  assign busy = (state == ACCUM);

endmodule

// File: tb/tb_da_slice_accumulator.sv
// Scoreboard bench for da_slice_accumulator: stimulus pushes expected
// outputs and their arrival cycle, a negedge monitor pops and compares.
module tb_da_slice_accumulator;

  localparam int PW     = 24;
  localparam int NSLICE = 16;
  localparam int YW     = PW + 3 + NSLICE;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 start;
  logic                 slice_valid;
  logic signed [PW-1:0] p0, p1, p2, p3, p4, p5, p6, p7;
  logic [YW-1:0]        y;
  logic                 y_valid;
  logic                 busy;
  logic                 frame_err;

  always #5 clk = ~clk;

  da_slice_accumulator #(.PW(PW), .NSLICE(NSLICE)) dut (
    .clk(clk), .reset(reset), .start(start), .slice_valid(slice_valid),
    .p0(p0), .p1(p1), .p2(p2), .p3(p3), .p4(p4), .p5(p5), .p6(p6), .p7(p7),
    .y(y), .y_valid(y_valid), .busy(busy), .frame_err(frame_err)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  bit mon_en = 1'b0;

  typedef struct {
    logic [YW-1:0] y;
    int            cyc;
  } exp_t;

  exp_t yq[$];
  int   errq[$];
  exp_t e;
  int   ec;

  logic signed [PW-1:0] fa0[NSLICE];
  logic signed [PW-1:0] fr[NSLICE];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  function automatic logic [YW-1:0] toy(input longint v);
    logic [63:0] t;
    t = v;
    return t[YW-1:0];
  endfunction

  // Golden Horner model over the current frame arrays.
  function automatic longint model();
    longint a;
    longint s;
    a = 0;
    for (int k = 0; k < NSLICE; k++) begin
      s = longint'(fa0[k]) + 7 * longint'(fr[k]);
      if (k == 0) a = -s;
      else        a = a * 2 + s;
    end
    return a;
  endfunction

  task automatic clear_frame();
    for (int k = 0; k < NSLICE; k++) begin
      fa0[k] = '0;
      fr[k]  = '0;
    end
  endtask

  task automatic send(input logic st, input logic signed [PW-1:0] a,
                      input logic signed [PW-1:0] r);
    start = st; slice_valid = 1'b1;
    p0 = a; p1 = r; p2 = r; p3 = r; p4 = r; p5 = r; p6 = r; p7 = r;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; slice_valid = 1'b0;
    p0 = '0; p1 = '0; p2 = '0; p3 = '0; p4 = '0; p5 = '0; p6 = '0; p7 = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic run_frame(input int gap_at, input int gap_len,
                           input logic [YW-1:0] ey,
                           output int first_e, output int last_e);
    first_e = 0;
    for (int i = 0; i < NSLICE; i++) begin
      send(i == 0, fa0[i], fr[i]);
      if (i == 0) begin
        first_e = cyc;
        chk("busy_in_frame", {63'd0, busy}, 64'd1);
      end
      if (i == gap_at) idle(gap_len);
    end
    last_e = cyc;
    yq.push_back('{y: ey, cyc: cyc + 1});
    chk("busy_after_last", {63'd0, busy}, 64'd0);
  endtask

  // Monitor: every y_valid / frame_err pulse must match a queued expectation.
  always @(negedge clk) begin
    if (mon_en) begin
      if (y_valid === 1'b1) begin
        if (yq.size() == 0) begin
          chk("unexpected_y_valid", 64'd1, 64'd0);
        end else begin
          e = yq.pop_front();
          chk("y_value", {{(64-YW){1'b0}}, y}, {{(64-YW){1'b0}}, e.y});
          chk("y_valid_cycle", 64'(cyc), 64'(e.cyc));
        end
      end
      if (frame_err === 1'b1) begin
        if (errq.size() == 0) begin
          chk("unexpected_frame_err", 64'd1, 64'd0);
        end else begin
          ec = errq.pop_front();
          chk("frame_err_cycle", 64'(cyc), 64'(ec));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int fe, le;
    reset = 1'b1; start = 1'b0; slice_valid = 1'b0;
    p0 = '0; p1 = '0; p2 = '0; p3 = '0; p4 = '0; p5 = '0; p6 = '0; p7 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_y", {{(64-YW){1'b0}}, y}, 64'd0);
    chk("reset_y_valid", {63'd0, y_valid}, 64'd0);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_frame_err", {63'd0, frame_err}, 64'd0);
    reset = 1'b0;
    mon_en = 1'b1;

    // Sign weighting: S=8 in every slice -> -8.
    for (int k = 0; k < NSLICE; k++) begin fa0[k] = 1; fr[k] = 1; end
    run_frame(-1, 0, 43'h7FF_FFFF_FFF8, fe, le);

    // MSB only -> -32768.
    clear_frame(); fa0[0] = 1;
    run_frame(-1, 0, 43'h7FF_FFFF_8000, fe, le);

    // LSB only -> 5.
    clear_frame(); fa0[15] = 5;
    run_frame(-1, 0, 43'd5, fe, le);

    // All p = -1 in last slice -> -8.
    clear_frame(); fa0[15] = -1; fr[15] = -1;
    run_frame(-1, 0, 43'h7FF_FFFF_FFF8, fe, le);
    idle(4);
    chk("y_hold", {{(64-YW){1'b0}}, y}, {{(64-YW){1'b0}}, 43'h7FF_FFFF_FFF8});

    // Back-to-back frames -> 3 then 7.
    clear_frame(); fa0[15] = 3;
    run_frame(-1, 0, 43'd3, fe, le);
    clear_frame(); fa0[15] = 7;
    run_frame(-1, 0, 43'd7, fe, le);

    // Gap of 3 idle cycles after slice 5 -> 3, three cycles later.
    clear_frame(); fa0[15] = 3;
    run_frame(5, 3, 43'd3, fe, le);
    chk("gap_latency", 64'(le - fe), 64'd18);

    // Early start: 7 slices then a restart; only the new frame completes.
    idle(2);
    for (int i = 0; i < 7; i++) send(i == 0, 1, 1);
    errq.push_back(cyc + 1);
    clear_frame(); fa0[15] = 9;
    run_frame(-1, 0, 43'd9, fe, le);

    // Stray slices in IDLE are ignored.
    idle(3);
    send(1'b0, 5, 5);
    chk("stray_busy", {63'd0, busy}, 64'd0);
    send(1'b0, 5, 5);
    chk("stray_busy2", {63'd0, busy}, 64'd0);
    idle(4);

    // Reset after slice 10 drops the frame.
    for (int i = 0; i < 11; i++) send(i == 0, 2, 2);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("midreset_y", {{(64-YW){1'b0}}, y}, 64'd0);
    chk("midreset_y_valid", {63'd0, y_valid}, 64'd0);
    chk("midreset_busy", {63'd0, busy}, 64'd0);
    chk("midreset_frame_err", {63'd0, frame_err}, 64'd0);
    idle(20);

    // Clean frame after reset: 2*1 + 2 = 4.
    clear_frame(); fa0[14] = 1; fa0[15] = 2;
    run_frame(-1, 0, 43'd4, fe, le);

    // Extremes: most negative partials in slice 0, most positive elsewhere.
    clear_frame();
    fa0[0] = 24'sh800000; fr[0] = 24'sh800000;
    for (int k = 1; k < NSLICE; k++) begin fa0[k] = 24'sh7FFFFF; fr[k] = 24'sh7FFFFF; end
    run_frame(-1, 0, toy(model()), fe, le);

    idle(6);
    chk("y_queue_empty", 64'(yq.size()), 64'd0);
    chk("err_queue_empty", 64'(errq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
